decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parameterised RV integer decode stage: full RV32I/RV64I base opcode set plus OP-32/OP-IMM-32, immediate generation for all formats, integrated register file with write-back bypass, load-use interlock, and valid/ready handshakes on both sides.
- Sits between the fetch stage and the execute stage.
- Successor to the single-format ALU/LOAD decoder: adds store, branch and jump decode, illegal detection, flush, and backpressure.

Parameters:
- XLEN, 64, datapath width (32 or 64); OP-32/OP-IMM-32 are illegal when XLEN=32.
- NREG, 32, architectural register count (32, or 16 for RV-E); any referenced index >= NREG is illegal.
- NOP_INST, 32'h00000013, instruction value used as the held/last instruction after reset.

Ports:
- CLK  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard the output slot and clear hazard tracking
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- wb_en  in  1  register write enable
- wb_rd  in  5  write index
- wb_value  in  XLEN  write data
- out_valid  out  1  decoded packet valid
- out_ready  in  1  execute accepts packet
- rd, rs1, rs2  out  5 each  register indices
- funct3  out  3  instruction funct3
- funct7  out  7  instruction funct7
- imm  out  XLEN  sign-extended immediate (I/S/B/U/J per format)
- op1  out  XLEN  operand 1
- op2  out  XLEN  operand 2
- store_data  out  XLEN  rs2 value for stores
- pc  out  XLEN  pc of the packet
- write_back, imm_flag, mem_acc, load_flag, store_flag, branch_flag, jump_flag, word_op, illegal  out  1 each  class flags

Behaviour:
- Reset (async, while reset=0):
  - Registers cleared to 0.
  - out_valid=0; all packet outputs 0.
  - Last-issued instruction = NOP_INST.
  - in_ready=1 once reset is released.
- Register file:
  - Writes on the CLK edge when wb_en and wb_rd!=0.
  - x0 reads 0 at all times.
  - Read bypass: if wb_en && wb_rd==index && index!=0, the read returns wb_value in the same cycle.
- Output register advance: advance = !out_valid || out_ready.
  - in_ready = advance && !hazard && !flush (combinational).
  - On advance with in_valid && !hazard: load the decoded packet and set out_valid=1.
  - On advance otherwise: out_valid=0 (bubble).
  - When not advancing: all outputs hold.
- Hazard (load-use):
  - Condition: out_valid && load_flag && rd!=0, and the incoming instruction reads rd.
  - rs1 is read by R, OP-32, I-ALU, OP-IMM-32, LOAD, STORE, BRANCH, JALR.
  - rs2 is read by R, OP-32, STORE, BRANCH.
  - Exactly one bubble is inserted; the instruction is accepted on the next advance.
- Decode by opcode:
  - R 0110011 / OP-32 0111011: op1=rs1v, op2=rs2v, write_back=1.
  - I-ALU 0010011 / OP-IMM-32 0011011: op1=rs1v, op2=imm_I, imm_flag=1.
  - LOAD 0000011: op1=rs1v, op2=imm_I, mem_acc=load_flag=1, write_back=1, funct3 passed through unchanged (width/sign).
  - STORE 0100011: op1=rs1v, op2=imm_S, store_data=rs2v, mem_acc=store_flag=1, write_back=0.
  - BRANCH 1100011: op1=rs1v, op2=rs2v, imm=imm_B, branch_flag=1, write_back=0.
  - LUI 0110111: op1=0, op2=imm_U.
  - AUIPC 0010111: op1=pc, op2=imm_U.
  - JAL 1101111: op1=pc, op2=imm_J, jump_flag=1.
  - JALR 1100111: op1=rs1v, op2=imm_I, jump_flag=1.
  - word_op=1 only for OP-32 and OP-IMM-32.
  - Any other opcode, or any register index >= NREG: illegal=1, write_back=0, mem_acc=0, out_valid=1.
  - write_back is forced to 0 whenever rd==0.
- Immediates: sign-extended from inst[31] to XLEN. imm_U = {inst[31:12], 12'b0} sign-extended.
- Flush: on the next edge out_valid=0 and hazard tracking cleared; any in_valid instruction that cycle is not accepted. Flush has priority over the hazard and the handshake.
- Simultaneous wb write and read of the same register: the bypass value is used, and the file is updated on the same edge.

Test Plan:
- x1=5, x2=7 via wb; issue add x3,x1,x2 -> next cycle out_valid=1, op1=5, op2=7, write_back=1, rd=3.
- ld x5,8(x1) then addi x6,x5,1 back-to-back, out_ready=1 -> ld packet; in_ready=0 for one cycle; bubble (out_valid=0); addi packet one cycle later.
- out_ready=0 for 3 cycles with in_valid=1 -> packet held stable, in_ready=0; release -> next instruction accepted on the same edge.
- sw x2,-4(x1) with x1=0x100, x2=0xAB -> op1=0x100, op2=all-ones...FC, store_data=0xAB, store_flag=1, write_back=0.
- wb_en writes x1=9 in the same cycle that addi x4,x1,1 is decoded -> op1=9 (bypass); opcode 0x7F -> illegal=1; NREG=16 with rs1=17 -> illegal=1.
- flush asserted with a load-use hazard pending -> out_valid=0 next cycle, hazard cleared; reset asserted mid-stream -> out_valid=0 immediately, registers 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I integer decode with register file, write-back
// bypass, load-use interlock and valid/ready handshakes on both sides.
module decode_stage #(
    parameter int          XLEN     = 64,
    parameter int          NREG     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] pc,
    output logic            write_back,
    output logic            imm_flag,
    output logic            mem_acc,
    output logic            load_flag,
    output logic            store_flag,
    output logic            branch_flag,
    output logic            jump_flag,
    output logic            word_op,
    output logic            illegal
);
    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_R32    = 7'b0111011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
        logic            write_back;
        logic            imm_flag;
        logic            mem_acc;
        logic            load_flag;
        logic            store_flag;
        logic            branch_flag;
        logic            jump_flag;
        logic            word_op;
        logic            illegal;
    } pkt_t;

    function automatic logic signed [XLEN-1:0] imm_i_f(input logic [31:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_s_f(input logic [31:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_b_f(input logic [31:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_u_f(input logic [31:0] inst);
        return {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_j_f(input logic [31:0] inst);
        return {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // x0 and out-of-range indices read as zero; a same-cycle write wins over the stored value
    function automatic logic [XLEN-1:0] rf_pick(input logic [4:0] idx, input logic [XLEN-1:0] stored,
                                                input logic byp_en, input logic [4:0] byp_idx,
                                                input logic [XLEN-1:0] byp_val);
        if (idx == 5'd0 || int'(idx) >= NREG) return '0;
        if (byp_en && byp_idx == idx) return byp_val;
        return stored;
    endfunction

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            out_valid_q, out_valid_d;
    pkt_t            pkt_q, pkt_d, dec;
    logic [31:7]     inst_q, inst_d;

    logic [6:0]      opcode;
    logic [4:0]      f_rd, f_rs1, f_rs2;
    logic [XLEN-1:0] rs1v, rs2v;
    logic            uses_rs1, uses_rs2, uses_rd, legal;
    logic            hazard, advance;

    assign opcode = in_inst[6:0];
    assign f_rd   = in_inst[11:7];
    assign f_rs1  = in_inst[19:15];
    assign f_rs2  = in_inst[24:20];

    assign rs1v = rf_pick(f_rs1, regs_q[f_rs1[RIDX_W-1:0]], wb_en, wb_rd, wb_value);
    assign rs2v = rf_pick(f_rs2, regs_q[f_rs2[RIDX_W-1:0]], wb_en, wb_rd, wb_value);

    // Opcode decode into the next packet, with legality and rd==x0 write-back suppression
    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OPC_R, OPC_R32: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1;
                dec.op1 = rs1v; dec.op2 = rs2v; dec.write_back = 1'b1;
                dec.word_op = (opcode == OPC_R32);
                if (opcode == OPC_R32 && XLEN != 64) legal = 1'b0;
            end
            OPC_IMM, OPC_IMM32: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1;
                dec.imm = imm_i_f(in_inst); dec.op1 = rs1v; dec.op2 = imm_i_f(in_inst);
                dec.imm_flag = 1'b1; dec.write_back = 1'b1;
                dec.word_op = (opcode == OPC_IMM32);
                if (opcode == OPC_IMM32 && XLEN != 64) legal = 1'b0;
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1;
                dec.imm = imm_i_f(in_inst); dec.op1 = rs1v; dec.op2 = imm_i_f(in_inst);
                dec.mem_acc = 1'b1; dec.load_flag = 1'b1; dec.write_back = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.imm = imm_s_f(in_inst); dec.op1 = rs1v; dec.op2 = imm_s_f(in_inst);
                dec.store_data = rs2v; dec.mem_acc = 1'b1; dec.store_flag = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.imm = imm_b_f(in_inst); dec.op1 = rs1v; dec.op2 = rs2v;
                dec.branch_flag = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                uses_rd = 1'b1;
                dec.imm = imm_u_f(in_inst); dec.op2 = imm_u_f(in_inst);
                dec.op1 = (opcode == OPC_AUIPC) ? in_pc : '0;
                dec.write_back = 1'b1;
            end
            OPC_JAL: begin
                uses_rd = 1'b1;
                dec.imm = imm_j_f(in_inst); dec.op1 = in_pc; dec.op2 = imm_j_f(in_inst);
                dec.jump_flag = 1'b1; dec.write_back = 1'b1;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1;
                dec.imm = imm_i_f(in_inst); dec.op1 = rs1v; dec.op2 = imm_i_f(in_inst);
                dec.jump_flag = 1'b1; dec.write_back = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if ((uses_rd && int'(f_rd) >= NREG) || (uses_rs1 && int'(f_rs1) >= NREG) ||
            (uses_rs2 && int'(f_rs2) >= NREG)) begin
            legal = 1'b0;
        end
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
        if (f_rd == 5'd0) dec.write_back = 1'b0;
    end

    // Load-use interlock against the packet currently held in the output slot
    always_comb begin
        hazard = out_valid_q && pkt_q.load_flag && (inst_q[11:7] != 5'd0) &&
                 ((uses_rs1 && f_rs1 == inst_q[11:7]) || (uses_rs2 && f_rs2 == inst_q[11:7]));
        advance  = !out_valid_q || out_ready;
        in_ready = advance && !hazard && !flush;
    end

    // Output slot next state: flush drops it, advance loads or bubbles, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        pkt_d       = pkt_q;
        inst_d      = inst_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            if (in_valid && !hazard) begin
                out_valid_d = 1'b1;
                pkt_d       = dec;
                inst_d      = in_inst[31:7];
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Register file write port; x0 and out-of-range indices are never written
    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != 5'd0 && int'(wb_rd) < NREG) regs_d[wb_rd[RIDX_W-1:0]] = wb_value;
    end

    // Register file storage
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Output slot registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
            inst_q      <= NOP_INST[31:7];
        end else begin
            out_valid_q <= out_valid_d;
            pkt_q       <= pkt_d;
            inst_q      <= inst_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign rd          = inst_q[11:7];
    assign funct3      = inst_q[14:12];
    assign rs1         = inst_q[19:15];
    assign rs2         = inst_q[24:20];
    assign funct7      = inst_q[31:25];
    assign imm         = pkt_q.imm;
    assign op1         = pkt_q.op1;
    assign op2         = pkt_q.op2;
    assign store_data  = pkt_q.store_data;
    assign pc          = pkt_q.pc;
    assign write_back  = pkt_q.write_back;
    assign imm_flag    = pkt_q.imm_flag;
    assign mem_acc     = pkt_q.mem_acc;
    assign load_flag   = pkt_q.load_flag;
    assign store_flag  = pkt_q.store_flag;
    assign branch_flag = pkt_q.branch_flag;
    assign jump_flag   = pkt_q.jump_flag;
    assign word_op     = pkt_q.word_op;
    assign illegal     = pkt_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions with hand-computed packets.
module tb_decode_stage;
    logic        CLK = 1'b0;
    logic        reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, wb_value, imm, op1, op2, store_data, pc;
    logic [4:0]  wb_rd, rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        write_back, imm_flag, mem_acc, load_flag, store_flag, branch_flag, jump_flag, word_op, illegal;
    // second instance with NREG=16
    logic        in_ready_b, out_valid_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [2:0]  funct3_b;
    logic [6:0]  funct7_b;
    logic [63:0] imm_b, op1_b, op2_b, store_data_b, pc_b;
    logic        write_back_b, imm_flag_b, mem_acc_b, load_flag_b, store_flag_b, branch_flag_b;
    logic        jump_flag_b, word_op_b, illegal_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm, op1, op2, sd, pc;
        logic [8:0]  fl;  // {wb, imm, mem, load, store, branch, jump, word, illegal}
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    decode_stage #(.XLEN(64), .NREG(32)) u_dut (
        .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_value(wb_value),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .op1(op1), .op2(op2),
        .store_data(store_data), .pc(pc), .write_back(write_back), .imm_flag(imm_flag),
        .mem_acc(mem_acc), .load_flag(load_flag), .store_flag(store_flag),
        .branch_flag(branch_flag), .jump_flag(jump_flag), .word_op(word_op), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .NREG(16)) u_dut16 (
        .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_value(wb_value),
        .out_valid(out_valid_b), .out_ready(out_ready), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
        .funct3(funct3_b), .funct7(funct7_b), .imm(imm_b), .op1(op1_b), .op2(op2_b),
        .store_data(store_data_b), .pc(pc_b), .write_back(write_back_b), .imm_flag(imm_flag_b),
        .mem_acc(mem_acc_b), .load_flag(load_flag_b), .store_flag(store_flag_b),
        .branch_flag(branch_flag_b), .jump_flag(jump_flag_b), .word_op(word_op_b), .illegal(illegal_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [4:0] r_s2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] im,
                                input logic [63:0] o1, input logic [63:0] o2, input logic [63:0] sd,
                                input logic [63:0] p, input logic [8:0] fl);
        exp_t e;
        e.rd = r_d; e.rs1 = r_s1; e.rs2 = r_s2; e.f3 = f3; e.f7 = f7;
        e.imm = im; e.op1 = o1; e.op2 = o2; e.sd = sd; e.pc = p; e.fl = fl;
        return e;
    endfunction

    // Monitor: every packet taken by execute is compared against the scoreboard head
    always @(negedge CLK) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_packet", {32'h0, in_pc[31:0]}, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fields", {39'h0, rd, rs1, rs2, funct3, funct7}, {39'h0, e.rd, e.rs1, e.rs2, e.f3, e.f7});
                chk("imm", imm, e.imm);
                chk("op1", op1, e.op1);
                chk("op2", op2, e.op2);
                chk("store_data", store_data, e.sd);
                chk("pc", pc, e.pc);
                chk("flags", {55'h0, write_back, imm_flag, mem_acc, load_flag, store_flag,
                              branch_flag, jump_flag, word_op, illegal}, {55'h0, e.fl});
            end
        end
    end

    task automatic issue(input logic [31:0] inst, input logic [63:0] p, input exp_t e, input bit push);
        bit ok = 1'b0;
        in_valid = 1'b1; in_inst = inst; in_pc = p;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = in_ready;
            if (ok && push) exp_q.push_back(e);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        chk("issue_accepted", {63'h0, ok}, 64'h1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [63:0] v);
        wb_en = 1'b1; wb_rd = r; wb_value = v;
        @(posedge CLK); #1;
        wb_en = 1'b0;
    endtask

    localparam logic [8:0] F_WB = 9'b100000000, F_IMM = 9'b110000000, F_LD = 9'b101100000;
    localparam logic [8:0] F_ST = 9'b001010000, F_BR = 9'b000001000, F_JMP = 9'b100000100;
    localparam logic [8:0] F_ILL = 9'b000000001;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_value = 64'h0; out_ready = 1'b1;

        // reset state
        @(negedge CLK); @(negedge CLK);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_fields", {39'h0, rd, rs1, rs2, funct3, funct7}, 64'h0);
        chk("rst_op1", op1, 64'h0);
        chk("rst_imm", imm, 64'h0);
        chk("rst_flags", {55'h0, write_back, imm_flag, mem_acc, load_flag, store_flag,
                          branch_flag, jump_flag, word_op, illegal}, 64'h0);
        @(posedge CLK); #1; reset = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge CLK); #1;

        // add x3,x1,x2 with x1=5, x2=7
        wb_write(5'd1, 64'd5);
        wb_write(5'd2, 64'd7);
        issue(32'h002081B3, 64'h1000, mk(3, 1, 2, 0, 0, 0, 5, 7, 0, 64'h1000, F_WB), 1);
        idle(2);

        // ld x5,8(x1) followed by addi x6,x5,1: one stall cycle and one bubble
        issue(32'h0080B283, 64'h1004, mk(5, 1, 8, 3, 0, 8, 5, 8, 0, 64'h1004, F_LD), 1);
        in_valid = 1'b1; in_inst = 32'h00128313; in_pc = 64'h1008;
        @(negedge CLK);
        chk("hazard_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("hazard_bubble", {63'h0, out_valid}, 64'h0);
        chk("hazard_release", {63'h0, in_ready}, 64'h1);
        exp_q.push_back(mk(6, 5, 1, 0, 0, 1, 0, 1, 0, 64'h1008, F_IMM));
        @(posedge CLK); #1; in_valid = 1'b0;
        idle(2);

        // backpressure: lui held for 3 cycles, auipc accepted on the release edge
        out_ready = 1'b0;
        issue(32'h800003B7, 64'h100C,
              mk(7, 0, 0, 0, 7'h40, 64'hFFFF_FFFF_8000_0000, 0, 64'hFFFF_FFFF_8000_0000, 0, 64'h100C, F_WB), 1);
        in_valid = 1'b1; in_inst = 32'h00001417; in_pc = 64'h2000;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
            chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_op2_hold", op2, 64'hFFFF_FFFF_8000_0000);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_release_ready", {63'h0, in_ready}, 64'h1);
        exp_q.push_back(mk(8, 0, 0, 1, 0, 64'h1000, 64'h2000, 64'h1000, 0, 64'h2000, F_WB));
        @(posedge CLK); #1; in_valid = 1'b0;
        idle(2);

        // store, branch, jal with negative immediates
        wb_write(5'd1, 64'h100);
        wb_write(5'd2, 64'hAB);
        issue(32'hFE20AE23, 64'h1010, mk(28, 1, 2, 2, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100,
              64'hFFFF_FFFF_FFFF_FFFC, 64'hAB, 64'h1010, F_ST), 1);
        issue(32'hFE2088E3, 64'h1014, mk(17, 1, 2, 0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF0, 64'h100,
              64'hAB, 0, 64'h1014, F_BR), 1);
        issue(32'hFF9FF0EF, 64'h3000, mk(1, 31, 25, 7, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3000,
              64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h3000, F_JMP), 1);
        idle(2);

        // write-back bypass on x1, then the stored value is visible
        wb_en = 1'b1; wb_rd = 5'd1; wb_value = 64'd9;
        issue(32'h00108213, 64'h1018, mk(4, 1, 1, 0, 0, 1, 9, 1, 0, 64'h1018, F_IMM), 1);
        wb_en = 1'b0;
        issue(32'h002081B3, 64'h101C, mk(3, 1, 2, 0, 0, 0, 9, 64'hAB, 0, 64'h101C, F_WB), 1);
        idle(2);

        // illegal opcode, then rs1=x17 which is out of range only for NREG=16
        issue(32'h0000007F, 64'h1020, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1020, F_ILL), 1);
        issue(32'h00088093, 64'h1024, mk(1, 17, 0, 0, 0, 0, 0, 0, 0, 64'h1024, F_IMM), 1);
        @(negedge CLK);
        chk("nreg16_valid", {63'h0, out_valid_b}, 64'h1);
        chk("nreg16_illegal", {63'h0, illegal_b}, 64'h1);
        chk("nreg16_wb", {63'h0, write_back_b}, 64'h0);
        @(posedge CLK); #1;
        idle(2);

        // flush while a load-use hazard is pending and execute is stalled
        out_ready = 1'b0;
        issue(32'h0080B283, 64'h102C, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        in_valid = 1'b1; in_inst = 32'h00128313; in_pc = 64'h1030; flush = 1'b1;
        @(negedge CLK);
        chk("flush_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge CLK); #1; flush = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        chk("flush_drop", {63'h0, out_valid}, 64'h0);
        chk("flush_hz_clear", {63'h0, in_ready}, 64'h1);
        exp_q.push_back(mk(6, 5, 1, 0, 0, 1, 0, 1, 0, 64'h1030, F_IMM));
        @(posedge CLK); #1; in_valid = 1'b0;
        idle(2);

        // asynchronous reset mid-stream clears the slot and the register file
        out_ready = 1'b0;
        issue(32'h002081B3, 64'h1038, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
        chk("mid_rst_op1", op1, 64'h0);
        chk("mid_rst_rd", {59'h0, rd}, 64'h0);
        @(posedge CLK); #1; reset = 1'b1; out_ready = 1'b1;
        issue(32'h002081B3, 64'h1040, mk(3, 1, 2, 0, 0, 0, 0, 0, 0, 64'h1040, F_WB), 1);
        idle(3);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
